// File: rtl/alu_packet_responder.sv
// alu_packet_responder
// Byte-stream packet engine that sits between a UART receiver and transmitter.
// A packet is: opcode, reserved, len_lsb, len_msb, payload. len counts the
// whole packet, header included.
//   0xEC        echo every payload byte back on the tx stream
//   0xA0 / 0xA1 fold little-endian 32-bit payload words with ADD / XOR and
//               answer with the 32-bit result, LSB first
// Unknown opcodes and bad lengths raise a single err_o pulse. The payload of
// such a packet is then discarded.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   rx_tdata_i/tvalid_i       incoming byte stream (ready/valid)
//   rx_tready_o
//   tx_tdata_o/tvalid_o       outgoing byte stream (ready/valid)
//   tx_tready_i
//   busy_o                    high while a packet is in progress
//   err_o                     one-cycle protocol error pulse
//
// Optional feature: define ALU_RESP_TIMEOUT_EN to abandon a packet after
// TIMEOUT_CYCLES_P cycles without an rx byte. When it is not defined, the
// block waits indefinitely.

module alu_packet_responder #(
   parameter int DATA_WIDTH_P     = 8,
   parameter int TIMEOUT_CYCLES_P = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
   input  logic                    rx_tvalid_i,
   output logic                    rx_tready_o,
   output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
   output logic                    tx_tvalid_o,
   input  logic                    tx_tready_i,
   output logic                    busy_o,
   output logic                    err_o
);

   localparam logic [2:0] HDR0  = 3'd0;
   localparam logic [2:0] HDR1  = 3'd1;
   localparam logic [2:0] HDR2  = 3'd2;
   localparam logic [2:0] HDR3  = 3'd3;
   localparam logic [2:0] ECHO  = 3'd4;
   localparam logic [2:0] ACCUM = 3'd5;
   localparam logic [2:0] RESP  = 3'd6;
   localparam logic [2:0] DRAIN = 3'd7;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hA0;
   localparam logic [7:0] OP_XOR  = 8'hA1;

   // The byte-oriented datapath below is written for 8-bit streams only.
   if (DATA_WIDTH_P != 8 || TIMEOUT_CYCLES_P < 1) begin : g_bad_param
      $error("alu_packet_responder: DATA_WIDTH_P must be 8 and TIMEOUT_CYCLES_P >= 1");
   end

   logic [2:0]  state;
   logic [7:0]  opcode;
   logic [7:0]  len_lsb;
   logic [15:0] remaining;
   logic [31:0] acc;
   logic [23:0] word;
   logic [1:0]  byte_idx;
   logic [1:0]  resp_cnt;
   logic        resp_loaded;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        err;

   logic        rx_ready;
   logic        rx_fire;
   logic        tx_fire;
   logic [15:0] hdr_len;
   logic [15:0] hdr_rem;
   logic        len_ok;
   logic [31:0] full_word;
   logic [31:0] acc_next;
   logic        tmo_hit;

   assign rx_fire   = rx_tvalid_i & rx_ready;
   assign tx_fire   = tx_valid & tx_tready_i;
   assign hdr_len   = {rx_tdata_i, len_lsb};
   assign hdr_rem   = hdr_len - 16'd4;
   assign len_ok    = (hdr_len >= 16'd8) && (hdr_len[1:0] == 2'b00);
   assign full_word = {rx_tdata_i, word};
   assign acc_next  = opcode[0] ? (acc ^ full_word) : (acc + full_word);

   assign tx_tdata_o  = tx_data;
   assign tx_tvalid_o = tx_valid;
   assign busy_o      = (state != HDR0);
   assign err_o       = err;
   assign rx_tready_o = rx_ready;

   // Ready is forced low during reset so that it rises in the first cycle after
   // reset is released. In ECHO, ready is granted only when the single tx
   // holding register can take a new byte in the same cycle.
   always_comb begin
      rx_ready = 1'b0;
      if (!rst) begin
         case (state)
            HDR0, HDR1, HDR2, HDR3, ACCUM, DRAIN: rx_ready = 1'b1;
            ECHO:                                 rx_ready = !tx_valid | tx_tready_i;
            default:                              rx_ready = 1'b0;
         endcase
      end
   end

`ifdef ALU_RESP_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   logic        tmo_watch;

   // Idle cycles are counted only while the block is waiting for more bytes of
   // a packet. In ECHO, the timeout is held off until the last echoed byte has
   // been handed to the transmitter.
   assign tmo_watch = (state == HDR1) || (state == HDR2) || (state == HDR3) ||
                      (state == ECHO) || (state == ACCUM) || (state == DRAIN);
   assign tmo_hit   = tmo_watch && !rx_fire && !((state == ECHO) && tx_valid) &&
                      (tmo_cnt >= 32'(TIMEOUT_CYCLES_P - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= 32'd0;
      end else if (rx_fire || !tmo_watch || tmo_hit) begin
         tmo_cnt <= 32'd0;
      end else if (tmo_cnt < 32'(TIMEOUT_CYCLES_P)) begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Main packet sequencer. A pending tx byte is cleared by default when the
   // transmitter takes it. States that produce a byte override that default.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= HDR0;
         opcode      <= 8'd0;
         len_lsb     <= 8'd0;
         remaining   <= 16'd0;
         acc         <= 32'd0;
         word        <= 24'd0;
         byte_idx    <= 2'd0;
         resp_cnt    <= 2'd0;
         resp_loaded <= 1'b0;
         tx_data     <= 8'd0;
         tx_valid    <= 1'b0;
         err         <= 1'b0;
      end else begin
         err <= 1'b0;
         if (tx_fire) tx_valid <= 1'b0;

         case (state)
            HDR0: if (rx_fire) begin
               opcode <= rx_tdata_i;
               state  <= HDR1;
            end
            HDR1: if (rx_fire) state <= HDR2;
            HDR2: if (rx_fire) begin
               len_lsb <= rx_tdata_i;
               state   <= HDR3;
            end
            HDR3: if (rx_fire) begin
               remaining <= hdr_rem;
               if (hdr_len < 16'd4) begin
                  err       <= 1'b1;
                  remaining <= 16'd0;
                  state     <= HDR0;
               end else if (opcode == OP_ECHO) begin
                  state <= (hdr_rem == 16'd0) ? HDR0 : ECHO;
               end else if ((opcode == OP_ADD || opcode == OP_XOR) && len_ok) begin
                  acc      <= 32'd0;
                  word     <= 24'd0;
                  byte_idx <= 2'd0;
                  state    <= ACCUM;
               end else begin
                  err   <= 1'b1;
                  state <= (hdr_rem == 16'd0) ? HDR0 : DRAIN;
               end
            end
            ECHO: if (rx_fire) begin
               tx_data   <= rx_tdata_i;
               tx_valid  <= 1'b1;
               remaining <= remaining - 16'd1;
               if (remaining == 16'd1) state <= HDR0;
            end
            // Bytes are shifted in from the top. After three bytes, the next
            // byte completes a little-endian word that is folded immediately.
            ACCUM: if (rx_fire) begin
               word      <= {rx_tdata_i, word[23:8]};
               byte_idx  <= byte_idx + 2'd1;
               remaining <= remaining - 16'd1;
               if (byte_idx == 2'd3) acc <= acc_next;
               if (remaining == 16'd1) begin
                  resp_cnt    <= 2'd0;
                  resp_loaded <= 1'b0;
                  state       <= RESP;
               end
            end
            // The first result byte waits until any echo byte still in the tx
            // register has left. Later bytes come from shifting the accumulator.
            RESP: begin
               if (!resp_loaded) begin
                  if (!tx_valid) begin
                     tx_data     <= acc[7:0];
                     tx_valid    <= 1'b1;
                     resp_loaded <= 1'b1;
                  end
               end else if (tx_fire) begin
                  if (resp_cnt == 2'd3) begin
                     acc   <= 32'd0;
                     state <= HDR0;
                  end else begin
                     tx_data  <= acc[15:8];
                     tx_valid <= 1'b1;
                     acc      <= {8'd0, acc[31:8]};
                     resp_cnt <= resp_cnt + 2'd1;
                  end
               end
            end
            DRAIN: if (rx_fire) begin
               remaining <= remaining - 16'd1;
               if (remaining == 16'd1) state <= HDR0;
            end
            default: state <= HDR0;
         endcase

         // A drained packet has already reported its error, so its timeout
         // stays silent.
         if (tmo_hit) begin
            err   <= (state != DRAIN);
            state <= HDR0;
         end
      end
   end

endmodule

// File: tb/tb_alu_packet_responder.sv
// tb_alu_packet_responder
// Self-checking bench for alu_packet_responder in its default build, where
// ALU_RESP_TIMEOUT_EN is not defined. The directed scenarios use literal
// expected bytes. The random scenario uses a packet-level reference model.
// The model computes echo data and ADD/XOR results directly from the packet
// bytes.

module tb_alu_packet_responder;

   typedef logic [7:0] u8_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   u8_t  rx_tdata = 8'd0;
   logic rx_tvalid = 1'b0;
   logic rx_tready;
   u8_t  tx_tdata;
   logic tx_tvalid;
   logic tx_tready = 1'b1;
   logic busy;
   logic err;

   int errors = 0;
   int checks = 0;

   u8_t got_tx[$];
   u8_t exp_tx[$];
   u8_t pkt[$];
   int  got_err = 0;
   int  exp_err = 0;
   int  stab_err = 0;
   int  ready_mode = 0;
   bit  gaps = 1'b0;
   bit  hung = 1'b0;

   logic prev_stall = 1'b0;
   u8_t  prev_data = 8'd0;

   alu_packet_responder dut (
      .clk         (clk),
      .rst         (rst),
      .rx_tdata_i  (rx_tdata),
      .rx_tvalid_i (rx_tvalid),
      .rx_tready_o (rx_tready),
      .tx_tdata_o  (tx_tdata),
      .tx_tvalid_o (tx_tvalid),
      .tx_tready_i (tx_tready),
      .busy_o      (busy),
      .err_o       (err)
   );

   // Clock generation: 10-time-unit period.
   always #5 clk = ~clk;

   // Transmitter model. Mode 0 always accepts bytes, mode 1 accepts them at
   // random, and mode 2 stalls.
   initial forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
         0:       tx_tready = 1'b1;
         1:       tx_tready = ($urandom_range(0, 2) != 0);
         default: tx_tready = 1'b0;
      endcase
   end

   // Mid-cycle monitor. This collects transmitted bytes, counts err_o pulses,
   // and flags a tx byte that changes or disappears while it is stalled.
   always @(negedge clk) begin
      if (!rst && prev_stall && (!tx_tvalid || tx_tdata !== prev_data)) stab_err++;
      if (tx_tvalid && tx_tready) got_tx.push_back(tx_tdata);
      if (err) got_err++;
      prev_stall = tx_tvalid && !tx_tready && !rst;
      prev_data  = tx_tdata;
   end

   // Packet-level reference model: appends the expected tx bytes and the
   // expected error count for one packet.
   function automatic void model_packet(input u8_t p[$]);
      int          len;
      logic [31:0] acc;
      logic [31:0] w;
      len = {p[3], p[2]};
      if (len < 4) begin
         exp_err++;
         return;
      end
      if (p[0] == 8'hEC) begin
         for (int i = 4; i < len; i++) exp_tx.push_back(p[i]);
         return;
      end
      if ((p[0] == 8'hA0 || p[0] == 8'hA1) && len >= 8 && (len % 4) == 0) begin
         acc = 32'd0;
         for (int i = 4; i < len; i += 4) begin
            w = 32'(p[i]) + (32'(p[i+1]) << 8) + (32'(p[i+2]) << 16) + (32'(p[i+3]) << 24);
            acc = (p[0] == 8'hA0) ? acc + w : acc ^ w;
         end
         for (int k = 0; k < 4; k++) exp_tx.push_back(acc[8*k +: 8]);
      end else begin
         exp_err++;
      end
   endfunction

   task automatic clear_scoreboard();
      got_tx.delete();
      exp_tx.delete();
      got_err  = 0;
      exp_err  = 0;
      stab_err = 0;
      hung     = 1'b0;
   endtask

   // Presents one byte and holds it until the DUT accepts it. The wait is
   // bounded; if the bound expires, hung is set.
   task automatic send_byte(input u8_t b);
      int n;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rx_tdata  = b;
      rx_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rx_tready && n < 3000) begin @(negedge clk); n++; end
      if (!rx_tready) hung = 1'b1;
      @(posedge clk);
      #1;
      rx_tvalid = 1'b0;
      rx_tdata  = u8_t'($urandom);
   endtask

   task automatic send_packet(input u8_t p[$]);
      foreach (p[i]) send_byte(p[i]);
   endtask

   // Waits, with a bound, for the DUT to return to HDR0 with no pending tx
   // byte. It then lets any late err_o pulse reach the monitor.
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || tx_tvalid) && n < 5000) begin @(negedge clk); n++; end
      if (busy || tx_tvalid) hung = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (rx_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_tready got=%b want=0", rx_tready); end
      checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_tvalid got=%b want=0", tx_tvalid); end
      checks++; if (tx_tdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_tdata got=%h want=00", tx_tdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b want=0", err); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (rx_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready got=%b want=1", rx_tready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_echo();
      clear_scoreboard();
      pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
      exp_tx = '{8'h41, 8'h42};
      send_packet(pkt);
      wait_idle();
      checks++; if (got_tx.size() !== exp_tx.size()) begin errors++; $display("[TB] FAIL echo_count got=%0d want=%0d", got_tx.size(), exp_tx.size()); end
      foreach (exp_tx[i]) begin
         checks++;
         if (i >= got_tx.size() || got_tx[i] !== exp_tx[i]) begin errors++; $display("[TB] FAIL echo_byte%0d want=%h", i, exp_tx[i]); end
      end
      checks++; if (got_err !== 0) begin errors++; $display("[TB] FAIL echo_err got=%0d want=0", got_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL echo_busy got=%b want=0", busy); end
      checks++; if (hung !== 1'b0) begin errors++; $display("[TB] FAIL echo_timeout got=%b want=0", hung); end
   endtask

   task automatic test_add_xor();
      clear_scoreboard();
      pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_packet(pkt);
      pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00};
      send_packet(pkt);
      exp_tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
      wait_idle();
      checks++; if (got_tx.size() !== exp_tx.size()) begin errors++; $display("[TB] FAIL addxor_count got=%0d want=%0d", got_tx.size(), exp_tx.size()); end
      foreach (exp_tx[i]) begin
         checks++;
         if (i >= got_tx.size() || got_tx[i] !== exp_tx[i]) begin errors++; $display("[TB] FAIL addxor_byte%0d want=%h", i, exp_tx[i]); end
      end
      checks++; if (got_err !== 0) begin errors++; $display("[TB] FAIL addxor_err got=%0d want=0", got_err); end
      checks++; if (hung !== 1'b0) begin errors++; $display("[TB] FAIL addxor_timeout got=%b want=0", hung); end
   endtask

   task automatic test_bad_opcode();
      clear_scoreboard();
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
      send_packet(pkt);
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
      send_packet(pkt);
      pkt = '{8'hA0, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
      send_packet(pkt);
      pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
      send_packet(pkt);
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
      send_packet(pkt);
      exp_tx = '{8'h7E, 8'h99};
      wait_idle();
      checks++; if (got_tx.size() !== exp_tx.size()) begin errors++; $display("[TB] FAIL badop_count got=%0d want=%0d", got_tx.size(), exp_tx.size()); end
      foreach (exp_tx[i]) begin
         checks++;
         if (i >= got_tx.size() || got_tx[i] !== exp_tx[i]) begin errors++; $display("[TB] FAIL badop_byte%0d want=%h", i, exp_tx[i]); end
      end
      checks++; if (got_err !== 3) begin errors++; $display("[TB] FAIL badop_err_pulses got=%0d want=3", got_err); end
      checks++; if (hung !== 1'b0) begin errors++; $display("[TB] FAIL badop_timeout got=%b want=0", hung); end
   endtask

   task automatic test_backpressure();
      int viol;
      int n;
      clear_scoreboard();
      // ADD response is held for 20 cycles.
      ready_mode = 2;
      pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h11, 8'h11, 8'h11, 8'h11};
      send_packet(pkt);
      n = 0;
      @(negedge clk);
      while (!tx_tvalid && n < 100) begin @(negedge clk); n++; end
      if (!tx_tvalid) hung = 1'b1;
      viol = 0;
      repeat (20) begin
         @(negedge clk);
         if (!tx_tvalid || rx_tready) viol++;
      end
      @(posedge clk);
      #1;
      ready_mode = 0;
      wait_idle();
      // The echo is held while the next rx byte waits.
      ready_mode = 2;
      pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hC1};
      send_packet(pkt);
      rx_tdata  = 8'hC2;
      rx_tvalid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (rx_tready) viol++;
      end
      @(posedge clk);
      #1;
      ready_mode = 0;
      send_byte(8'hC2);
      send_byte(8'hC3);
      send_byte(8'hC4);
      wait_idle();
      exp_tx = '{8'h23, 8'h45, 8'h67, 8'h89, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      checks++; if (got_tx.size() !== exp_tx.size()) begin errors++; $display("[TB] FAIL bp_count got=%0d want=%0d", got_tx.size(), exp_tx.size()); end
      foreach (exp_tx[i]) begin
         checks++;
         if (i >= got_tx.size() || got_tx[i] !== exp_tx[i]) begin errors++; $display("[TB] FAIL bp_byte%0d want=%h", i, exp_tx[i]); end
      end
      checks++; if (viol !== 0) begin errors++; $display("[TB] FAIL bp_stall_ready got=%0d bad cycles want=0", viol); end
      checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL bp_tx_stable got=%0d changes want=0", stab_err); end
      checks++; if (got_err !== 0) begin errors++; $display("[TB] FAIL bp_err got=%0d want=0", got_err); end
      checks++; if (hung !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout got=%b want=0", hung); end
   endtask

   task automatic test_reset_mid_packet();
      clear_scoreboard();
      pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
      send_packet(pkt);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
      checks++; if (rx_tready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rx_tready got=%b want=0", rx_tready); end
      checks++; if ({tx_tvalid, tx_tdata, err} !== 10'd0) begin errors++; $display("[TB] FAIL midrst_tx got=%b want=0", {tx_tvalid, tx_tdata, err}); end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_scoreboard();
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
      send_packet(pkt);
      wait_idle();
      checks++; if (got_tx.size() !== 1) begin errors++; $display("[TB] FAIL midrst_count got=%0d want=1", got_tx.size()); end
      checks++; if (got_tx.size() < 1 || got_tx[0] !== 8'h33) begin errors++; $display("[TB] FAIL midrst_byte want=33"); end
      checks++; if (got_err !== 0) begin errors++; $display("[TB] FAIL midrst_err got=%0d want=0", got_err); end
   endtask

   task automatic test_random();
      int   kind;
      int   len;
      u8_t  op;
      clear_scoreboard();
      ready_mode = 1;
      gaps = 1'b1;
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 4);
         op   = u8_t'($urandom);
         case (kind)
            0: begin op = 8'hEC; len = $urandom_range(4, 12); end
            1: begin op = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'hA1; len = 4 * $urandom_range(2, 4); end
            2: begin op = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'hA1; len = $urandom_range(4, 11); end
            3: begin if (op == 8'hEC || op == 8'hA0 || op == 8'hA1) op = 8'h55; len = $urandom_range(4, 9); end
            default: len = $urandom_range(0, 3);
         endcase
         pkt.delete();
         pkt.push_back(op);
         pkt.push_back(u8_t'($urandom));
         pkt.push_back(len[7:0]);
         pkt.push_back(len[15:8]);
         for (int i = 4; i < len; i++) pkt.push_back(u8_t'($urandom));
         model_packet(pkt);
         send_packet(pkt);
      end
      ready_mode = 0;
      gaps = 1'b0;
      wait_idle();
      checks++; if (got_tx.size() !== exp_tx.size()) begin errors++; $display("[TB] FAIL rand_count got=%0d want=%0d", got_tx.size(), exp_tx.size()); end
      foreach (exp_tx[i]) begin
         checks++;
         if (i >= got_tx.size() || got_tx[i] !== exp_tx[i]) begin errors++; $display("[TB] FAIL rand_byte%0d want=%h", i, exp_tx[i]); end
      end
      checks++; if (got_err !== exp_err) begin errors++; $display("[TB] FAIL rand_err got=%0d want=%0d", got_err, exp_err); end
      checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL rand_tx_stable got=%0d want=0", stab_err); end
      checks++; if (hung !== 1'b0) begin errors++; $display("[TB] FAIL rand_timeout got=%b want=0", hung); end
   endtask

   initial begin
      test_reset();
      test_echo();
      test_add_xor();
      test_bad_opcode();
      test_backpressure();
      test_reset_mid_packet();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_packet_responder.md
ALU_PACKET_RESPONDER -- requirements
Module: alu_packet_responder

Interface
REQ-001 Parameter: DATA_WIDTH_P, default 8, byte width of both streams; only 8 is supported.
REQ-002 Parameter: TIMEOUT_CYCLES_P, default 65535, inter-byte timeout in clk cycles (used only under REQ-027).
REQ-003 Port: clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: rx_tdata_i  input  8  byte from UART receiver.
REQ-006 Port: rx_tvalid_i  input  1  rx byte valid.
REQ-007 Port: rx_tready_o  output  1  block accepts rx byte.
REQ-008 Port: tx_tdata_o  output  8  byte to UART transmitter.
REQ-009 Port: tx_tvalid_o  output  1  tx byte valid.
REQ-010 Port: tx_tready_i  input  1  transmitter accepts tx byte.
REQ-011 Port: busy_o  output  1  high whenever state is not HDR0.
REQ-012 Port: err_o  output  1  one-cycle pulse on protocol error.

Function
REQ-013 Packet format SHALL be: opcode, reserved, len_lsb, len_msb, payload; len = total bytes including 4-byte header, unsigned 16-bit.
REQ-014 Transfer SHALL occur on a cycle with valid and ready both high; tx_tdata_o SHALL stay stable while tx_tvalid_o=1 and tx_tready_i=0.
REQ-015 States SHALL be HDR0, HDR1, HDR2, HDR3, ECHO, ACCUM, RESP, DRAIN; HDR0..HDR3 advance one per accepted byte, rx_tready_o=1 in HDR*, ACCUM, DRAIN.
REQ-016 At HDR3 accept, remaining = len-4; dispatch: opcode 0xEC -> ECHO; 0xA0 (ADD) or 0xA1 (XOR) -> ACCUM; any dispatch with remaining=0 and valid opcode returns to HDR0 (ECHO) or RESP (not allowed, see REQ-018).
REQ-017 ECHO: rx_tready_o = !tx_tvalid_o | tx_tready_i; byte accepted in cycle N SHALL appear on tx_tdata_o with tx_tvalid_o=1 in cycle N+1; after last payload byte, return to HDR0.
REQ-018 ADD/XOR validity: len >= 8 and (len-4) mod 4 = 0; otherwise error.
REQ-019 ACCUM: payload bytes assembled little-endian into 32-bit words; each complete word folded into 32-bit accumulator (ADD modulo 2^32, XOR bitwise), accumulator initialised to 0 at dispatch.
REQ-020 After last payload byte, RESP: rx_tready_o=0; accumulator emitted as 4 bytes LSB first; after 4th byte accepted, return to HDR0.
REQ-021 Unknown opcode or invalid length (len >= 4): err_o pulses in cycle after HDR3 accept; state DRAIN discards len-4 bytes (none if 0), then HDR0; no tx output.
REQ-022 len < 4: err_o pulse, return to HDR0 directly, no drain.
REQ-023 At most one err_o pulse per packet.

Reset
REQ-024 While rst=1: state HDR0, rx_tready_o=0, tx_tvalid_o=0, tx_tdata_o=0, busy_o=0, err_o=0, accumulator and counters 0.
REQ-025 rx_tready_o SHALL assert the first cycle after rst deasserts.
REQ-026 Reset mid-packet or mid-response SHALL abandon it; pending tx byte is dropped.

Configuration
REQ-027 Macro ALU_RESP_TIMEOUT_EN defined: counter clears on each rx transfer, increments in HDR1..HDR3, ECHO, ACCUM, DRAIN while no transfer; reaching TIMEOUT_CYCLES_P pulses err_o and returns to HDR0 (ECHO: after pending tx byte completes).
REQ-028 Macro undefined: no counter; block waits indefinitely for bytes.

Verification
REQ-029 Echo: EC 00 06 00 41 42 -> tx 41 42, err_o never high, busy_o low afterward.
REQ-030 Add wrap: A0 00 0C 00 01 00 00 00 FF FF FF FF -> tx 00 00 00 00; XOR: A1 00 0C 00 0F 00 00 00 F0 00 00 00 -> tx FF 00 00 00.
REQ-031 Bad opcode: 55 00 06 00 AA BB then EC 00 05 00 7E -> one err_o pulse, tx only 7E; A0 00 06 00 11 22 -> one err_o pulse, no tx.
REQ-032 Backpressure: tx_tready_i low 20 cycles during ADD response and during echo -> tx_tdata_o stable, rx_tready_o low in echo, no byte lost or duplicated.
REQ-033 Reset: assert rst after A0 00 0C 00 01 -> all outputs zero; then EC 00 05 00 33 -> tx 33.
REQ-034 Timeout (ALU_RESP_TIMEOUT_EN, TIMEOUT_CYCLES_P=100): EC 00 08 00 01 then 150 idle cycles -> tx 01, one err_o pulse, HDR0; following EC 00 05 00 5A -> tx 5A.
